// File: rtl/sram_like_mem_slave.sv
// Responder end of the sram-like data bus, backed by a word-organised RAM with programmable accept/data delays.
// Optional randomised extra latency is enabled by defining SRAM_LIKE_SLAVE_RAND_LAT_EN.
module sram_like_mem_slave #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned ADDR_OK_DELAY = 1,
    parameter int unsigned DATA_LAT      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned WORDS = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, AWAIT, DWAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [3:0]              mask_q, mask_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             ram [WORDS];

    logic                    addr_ok_c;
    logic [CNT_W-1:0]        extra_c;
    logic [CNT_W-1:0]        aw_load_c;
    logic [CNT_W-1:0]        dl_load_c;
    logic [ADDR_WIDTH-1:0]   req_idx_c;
    logic                    unused_addr_c;

    assign req_idx_c     = data_addr[ADDR_WIDTH+1:2];
    assign unused_addr_c = ^data_addr[31:ADDR_WIDTH+2];

`ifdef SRAM_LIKE_SLAVE_RAND_LAT_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign extra_c = {3'b000, lfsr_q[1:0]};
`else
    assign extra_c = '0;
`endif

    // A zero load skips the wait state so addr_ok/data_ok land exactly on the programmed cycle.
    assign aw_load_c = CNT_W'(ADDR_OK_DELAY) + extra_c;
    assign dl_load_c = CNT_W'(DATA_LAT - 1) + extra_c;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << a;
            2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        addr_ok_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_req) begin
                    if (aw_load_c == '0) begin
                        addr_ok_c = 1'b1;
                    end else begin
                        state_d = AWAIT;
                        cnt_d   = aw_load_c - CNT_W'(1);
                    end
                end
            end
            AWAIT: begin
                if (!data_req) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    addr_ok_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DWAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!wr_q) begin
                        rdata_d = ram[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake: capture the request and start the data phase
        if (addr_ok_c) begin
            wr_d    = data_wr;
            idx_d   = req_idx_c;
            mask_d  = lane_mask(data_size, data_addr[1:0]);
            wdata_d = data_wdata;
            if (dl_load_c == '0) begin
                state_d = RESP;
                if (!data_wr) begin
                    rdata_d = ram[req_idx_c];
                end
            end else begin
                state_d = DWAIT;
                cnt_d   = dl_load_c - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Write commits on the edge ending RESP; a reset before then drops it.
    always_ff @(posedge clk) begin
        if (state_q == RESP && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) begin
                    ram[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign data_addr_ok = addr_ok_c;
    assign data_data_ok = (state_q == RESP);
    assign data_rdata   = rdata_q;

endmodule
